// File: rtl/mips_seq_pkg.sv
// Shared definitions for the MIPS arithmetic sequencer: FSM state encoding and
// instruction-register field positions.
package mips_seq_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        EXCEPT    = 3'd4
    } seq_state_e;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int PC_STEP    = 4;

endpackage

// File: rtl/mips_arith_sequencer_if.sv
// Instruction-fetch, decoder and datapath-control bundle of the sequencer.
// master = sequencer side, slave = memory/decoder/datapath side.
interface mips_arith_sequencer_if #(
    parameter int PC_WIDTH = 32
);
    logic                inst_valid;
    logic [31:0]         inst;
    logic                inst_ready;
    logic [PC_WIDTH-1:0] pc;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                dec_except;
    logic                dec_writeenable;
    logic                alu_en;
    logic                rf_we;
    logic                exc_valid;
    logic [PC_WIDTH-1:0] exc_pc;
    logic                exc_ack;
    logic                halt;

    modport master (
        input  inst_valid, inst, dec_except, dec_writeenable, exc_ack, halt,
        output inst_ready, pc, opcode, funct, alu_en, rf_we, exc_valid, exc_pc
    );

    modport slave (
        output inst_valid, inst, dec_except, dec_writeenable, exc_ack, halt,
        input  inst_ready, pc, opcode, funct, alu_en, rf_we, exc_valid, exc_pc
    );
endinterface

// File: rtl/mips_seq_exec_timer.sv
// Down-counter that measures the EXECUTE dwell time; done_o is high when the
// count has reached zero.
module mips_seq_exec_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins over decrement, and the counter parks at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == {W{1'b0}});
endmodule

// File: rtl/mips_arith_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller with exception trap.
// Define MIPS_SEQ_PERF_EN to add the retired_cnt/exc_cnt performance counters.
module mips_arith_sequencer
    import mips_seq_pkg::*;
#(
    parameter int                   PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = 32'h0040_0000,
    parameter int                   EXEC_CYCLES = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    mips_arith_sequencer_if.master        bus
`ifdef MIPS_SEQ_PERF_EN
    ,
    output logic [31:0]                   retired_cnt,
    output logic [15:0]                   exc_cnt
`endif
);
    localparam logic [3:0]          EXEC_LOAD = 4'(EXEC_CYCLES - 1);
    localparam logic [PC_WIDTH-1:0] PC_INC    = PC_WIDTH'(PC_STEP);

    seq_state_e          state_q, state_d;
    logic [31:0]         ir_q, ir_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] exc_pc_q, exc_pc_d;
    logic                exc_valid_q, exc_valid_d;
    logic                inst_ready_q, inst_ready_d;
    logic                alu_en_q, alu_en_d;
    logic                rf_we_q, rf_we_d;
    logic                timer_load_s;
    logic                timer_dec_s;
    logic                timer_done_s;
    logic                ir_unused_s;

    mips_seq_exec_timer #(.W(4)) u_exec_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (timer_load_s),
        .dec_i      (timer_dec_s),
        .load_val_i (EXEC_LOAD),
        .done_o     (timer_done_s)
    );

    // Next-state and next-output decode for the instruction sequencer.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        pc_d         = pc_q;
        exc_pc_d     = exc_pc_q;
        exc_valid_d  = exc_valid_q;
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;

        case (state_q)
            FETCH: begin
                if (bus.inst_valid && inst_ready_q) begin
                    ir_d    = bus.inst;
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                if (bus.dec_except) begin
                    exc_valid_d = 1'b1;
                    exc_pc_d    = pc_q;
                    state_d     = EXCEPT;
                end else begin
                    timer_load_s = 1'b1;
                    state_d      = EXECUTE;
                end
            end
            EXECUTE: begin
                if (timer_done_s) begin
                    state_d = WRITEBACK;
                end else begin
                    timer_dec_s = 1'b1;
                    state_d     = EXECUTE;
                end
            end
            WRITEBACK: begin
                pc_d    = pc_q + PC_INC;
                state_d = FETCH;
            end
            EXCEPT: begin
                if (bus.exc_ack) begin
                    exc_valid_d = 1'b0;
                    pc_d        = exc_pc_q + PC_INC;
                    state_d     = FETCH;
                end else begin
                    state_d = EXCEPT;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Outputs are registered from the state being entered so they align with it.
        inst_ready_d = (state_d == FETCH) && !bus.halt;
        alu_en_d     = (state_d == EXECUTE);
        rf_we_d      = (state_d == WRITEBACK) && bus.dec_writeenable;
    end

    // State, IR, PC, exception and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            ir_q         <= 32'h0000_0000;
            pc_q         <= RESET_PC;
            exc_pc_q     <= {PC_WIDTH{1'b0}};
            exc_valid_q  <= 1'b0;
            inst_ready_q <= 1'b0;
            alu_en_q     <= 1'b0;
            rf_we_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            pc_q         <= pc_d;
            exc_pc_q     <= exc_pc_d;
            exc_valid_q  <= exc_valid_d;
            inst_ready_q <= inst_ready_d;
            alu_en_q     <= alu_en_d;
            rf_we_q      <= rf_we_d;
        end
    end

`ifdef MIPS_SEQ_PERF_EN
    logic [31:0] retired_cnt_q;
    logic [15:0] exc_cnt_q;

    // Retired-instruction and trap counters; both wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            retired_cnt_q <= 32'h0000_0000;
            exc_cnt_q     <= 16'h0000;
        end else begin
            if (state_q == WRITEBACK) begin
                retired_cnt_q <= retired_cnt_q + 32'h0000_0001;
            end else begin
                retired_cnt_q <= retired_cnt_q;
            end
            if ((state_q == DECODE) && (state_d == EXCEPT)) begin
                exc_cnt_q <= exc_cnt_q + 16'h0001;
            end else begin
                exc_cnt_q <= exc_cnt_q;
            end
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign exc_cnt     = exc_cnt_q;
`endif

    assign bus.inst_ready = inst_ready_q;
    assign bus.pc         = pc_q;
    assign bus.opcode     = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign bus.funct      = ir_q[FUNCT_MSB:FUNCT_LSB];
    assign bus.alu_en     = alu_en_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.exc_valid  = exc_valid_q;
    assign bus.exc_pc     = exc_pc_q;
    assign ir_unused_s    = ^ir_q[25:6];
endmodule

// File: tb/tb_mips_arith_sequencer.sv
// Self-checking bench: directed and random instructions against a
// transaction-level model of retirement latency, PC progression and traps.
module tb_mips_arith_sequencer;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          EXEC_A = 1;
    localparam int          EXEC_B = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mips_arith_sequencer_if #(.PC_WIDTH(32)) bus_a ();
    mips_arith_sequencer_if #(.PC_WIDTH(32)) bus_b ();

`ifdef MIPS_SEQ_PERF_EN
    logic [31:0] ret_a, ret_b;
    logic [15:0] exc_a, exc_b;
`endif

    mips_arith_sequencer #(.PC_WIDTH(32), .RESET_PC(RST_PC), .EXEC_CYCLES(EXEC_A)) u_dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
`ifdef MIPS_SEQ_PERF_EN
        , .retired_cnt (ret_a), .exc_cnt (exc_a)
`endif
    );

    mips_arith_sequencer #(.PC_WIDTH(32), .RESET_PC(RST_PC), .EXEC_CYCLES(EXEC_B)) u_dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
`ifdef MIPS_SEQ_PERF_EN
        , .retired_cnt (ret_b), .exc_cnt (exc_b)
`endif
    );

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] model_pc;
    int          model_retired = 0;
    int          model_exc = 0;
    time         we_times[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction through DUT A; starts and ends just after a falling edge.
    task automatic run_a(input logic [31:0] word, input logic we, input logic exc);
        logic [31:0] w;
        int          budget;
        w = word;
        if (exc) w[31:26] = 6'h3F;
        bus_a.inst            = w;
        bus_a.inst_valid      = 1'b1;
        bus_a.dec_writeenable = we;
        bus_a.dec_except      = exc;
        budget = 0;
        while (bus_a.inst_ready !== 1'b1 && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        check("a_ready_wait", 32'(budget < 20), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus_a.inst_valid = 1'b0;
        check("a_opcode", {26'd0, bus_a.opcode}, {26'd0, w[31:26]});
        check("a_funct", {26'd0, bus_a.funct}, {26'd0, w[5:0]});
        check("a_pc_decode", bus_a.pc, model_pc);
        check("a_ready_decode", {31'd0, bus_a.inst_ready}, 32'd0);
        if (exc) begin
            @(negedge clock);
            check("a_exc_valid", {31'd0, bus_a.exc_valid}, 32'd1);
            check("a_exc_pc", bus_a.exc_pc, model_pc);
            check("a_exc_alu", {31'd0, bus_a.alu_en}, 32'd0);
            check("a_exc_ready", {31'd0, bus_a.inst_ready}, 32'd0);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clock);
                check("a_exc_rfwe", {31'd0, bus_a.rf_we}, 32'd0);
            end
            check("a_exc_hold", {31'd0, bus_a.exc_valid}, 32'd1);
            bus_a.exc_ack = 1'b1;
            @(negedge clock);
            bus_a.exc_ack = 1'b0;
            model_pc = model_pc + 32'd4;
            model_exc++;
            check("a_ack_valid", {31'd0, bus_a.exc_valid}, 32'd0);
            check("a_ack_pc", bus_a.pc, model_pc);
            check("a_ack_ready", {31'd0, bus_a.inst_ready}, 32'd1);
        end else begin
            for (int k = 0; k < EXEC_A; k++) begin
                @(negedge clock);
                check("a_alu_on", {31'd0, bus_a.alu_en}, 32'd1);
                check("a_rfwe_early", {31'd0, bus_a.rf_we}, 32'd0);
            end
            @(negedge clock);
            check("a_alu_off", {31'd0, bus_a.alu_en}, 32'd0);
            check("a_rfwe", {31'd0, bus_a.rf_we}, {31'd0, we});
            check("a_pc_wb", bus_a.pc, model_pc);
            if (bus_a.rf_we === 1'b1) we_times.push_back($time);
            @(negedge clock);
            model_pc = model_pc + 32'd4;
            model_retired++;
            check("a_pc_next", bus_a.pc, model_pc);
            check("a_ready_next", {31'd0, bus_a.inst_ready}, 32'd1);
            check("a_rfwe_off", {31'd0, bus_a.rf_we}, 32'd0);
        end
    endtask

    initial begin
        int alu_cnt;
        int rf_cnt;
        int rdy_cnt;
        int budget;

        bus_a.inst_valid = 1'b0; bus_a.inst = 32'd0; bus_a.dec_except = 1'b0;
        bus_a.dec_writeenable = 1'b0; bus_a.exc_ack = 1'b0; bus_a.halt = 1'b0;
        bus_b.inst_valid = 1'b0; bus_b.inst = 32'd0; bus_b.dec_except = 1'b0;
        bus_b.dec_writeenable = 1'b0; bus_b.exc_ack = 1'b0; bus_b.halt = 1'b0;
        model_pc = RST_PC;

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_pc", bus_a.pc, RST_PC);
        check("rst_ready", {31'd0, bus_a.inst_ready}, 32'd0);
        check("rst_rfwe", {31'd0, bus_a.rf_we}, 32'd0);
        check("rst_alu", {31'd0, bus_a.alu_en}, 32'd0);
        check("rst_exc", {31'd0, bus_a.exc_valid}, 32'd0);
        check("rst_exc_pc", bus_a.exc_pc, 32'd0);
        check("rst_opcode", {26'd0, bus_a.opcode}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rel_ready", {31'd0, bus_a.inst_ready}, 32'd1);
        check("rel_pc", bus_a.pc, RST_PC);

        // exc_ack outside EXCEPT has no effect
        bus_a.exc_ack = 1'b1;
        @(negedge clock);
        bus_a.exc_ack = 1'b0;
        check("stray_ack_pc", bus_a.pc, RST_PC);
        check("stray_ack_exc", {31'd0, bus_a.exc_valid}, 32'd0);

        // add $3,$1,$2 then three back-to-back instructions
        we_times.delete();
        run_a(32'h0022_1820, 1'b1, 1'b0);
        run_a($urandom & 32'h03FF_FFFF, 1'b1, 1'b0);
        run_a($urandom & 32'h03FF_FFFF, 1'b1, 1'b0);
        run_a($urandom & 32'h03FF_FFFF, 1'b1, 1'b0);
        check("b2b_count", we_times.size(), 32'd4);
        if (we_times.size() == 4) begin
            for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(we_times[i] - we_times[i-1]), 32'd40);
        end
        check("b2b_pc", bus_a.pc, 32'h0040_0010);

        // Trap on illegal opcode
        run_a(32'hFC00_0000, 1'b0, 1'b1);

        // Random instruction stream with occasional idle gaps
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
            run_a($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
        end
`ifdef MIPS_SEQ_PERF_EN
        check("perf_retired", ret_a, 32'(model_retired));
        check("perf_exc", {16'd0, exc_a}, 32'(model_exc));
`endif

        // DUT B: halt raised during DECODE, EXEC_CYCLES=3
        bus_b.inst = 32'h0022_1820; bus_b.dec_writeenable = 1'b1; bus_b.inst_valid = 1'b1;
        budget = 0;
        while (bus_b.inst_ready !== 1'b1 && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        check("b_ready_wait", 32'(budget < 20), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus_b.inst_valid = 1'b0;
        bus_b.halt = 1'b1;
        alu_cnt = 0; rf_cnt = 0; rdy_cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus_b.alu_en === 1'b1) alu_cnt++;
            if (bus_b.rf_we === 1'b1) rf_cnt++;
            if (bus_b.inst_ready !== 1'b0) rdy_cnt++;
        end
        check("halt_alu_cycles", 32'(alu_cnt), 32'd3);
        check("halt_rfwe_pulses", 32'(rf_cnt), 32'd1);
        check("halt_ready_low", 32'(rdy_cnt), 32'd0);
        check("halt_pc", bus_b.pc, RST_PC + 32'd4);
        bus_b.halt = 1'b0;
        @(negedge clock);
        check("unhalt_ready", {31'd0, bus_b.inst_ready}, 32'd1);

        // DUT B: reset in the middle of EXECUTE abandons the instruction
        bus_b.inst_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus_b.inst_valid = 1'b0;
        @(negedge clock);
        check("mid_alu_on", {31'd0, bus_b.alu_en}, 32'd1);
        reset_n = 1'b0;
        rf_cnt = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus_b.rf_we !== 1'b0) rf_cnt++;
        end
        reset_n = 1'b1;
        model_pc = RST_PC;
        repeat (4) begin
            @(negedge clock);
            if (bus_b.rf_we !== 1'b0) rf_cnt++;
        end
        check("mid_rst_rfwe", 32'(rf_cnt), 32'd0);
        check("mid_rst_pc", bus_b.pc, RST_PC);
        check("mid_rst_ready", {31'd0, bus_b.inst_ready}, 32'd1);
        check("mid_rst_alu", {31'd0, bus_b.alu_en}, 32'd0);
        check("mid_rst_pc_a", bus_a.pc, model_pc);
`ifdef MIPS_SEQ_PERF_EN
        check("mid_rst_retired", ret_b, 32'd0);
`endif

        // DUT A keeps working after the reset
        run_a(32'h0022_1820, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mips_arith_sequencer.md
Name: mips_arith_sequencer

Overview:
- Multi-cycle control FSM for the arithmetic datapath: fetches an instruction over a valid/ready handshake and latches it in an instruction register (IR).
- Presents IR opcode/funct to mips_decode and sequences ALU execute and register-file writeback.
- Advances the PC; traps on decoder exceptions.
- Sits between instruction memory and the decoder/ALU/regfile datapath.

Parameters:
PC_WIDTH, 32, width of program counter
RESET_PC, 32'h0040_0000, PC value after reset
EXEC_CYCLES, 1, cycles spent in EXECUTE (1..15); models ALU latency

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset, sampled on rising clock edge
inst_valid  input  1  instruction memory presents inst
inst  input  32  instruction word
inst_ready  output  1  sequencer accepts inst this cycle
pc  output  PC_WIDTH  current instruction address
opcode  output  6  IR[31:26] to decoder
funct  output  6  IR[5:0] to decoder
dec_except  input  1  decoder: unrecognised opcode/funct
dec_writeenable  input  1  decoder: instruction writes the regfile
alu_en  output  1  ALU operands/result register enable
rf_we  output  1  register-file write strobe
exc_valid  output  1  exception pending (sticky)
exc_pc  output  PC_WIDTH  address of faulting instruction
exc_ack  input  1  clears exception; resumes at pc+4
halt  input  1  stop fetching after current instruction retires

Behaviour:
- Reset (reset_n=0 at edge): state=FETCH, pc=RESET_PC, IR=0, exc_valid=0, exc_pc=0, inst_ready=0, alu_en=0, rf_we=0.
- Reset mid-instruction abandons it; no rf_we is issued.
- All outputs are registered or decoded purely from state. opcode/funct are always IR fields.
- FETCH:
  - inst_ready=1 iff halt=0.
  - Transfer occurs when inst_valid && inst_ready: IR<=inst, next state DECODE.
  - If halt=1, stays in FETCH with inst_ready=0.
- DECODE (1 cycle): decoder is combinational on IR.
  - dec_except=1 -> EXCEPT: exc_valid<=1, exc_pc<=pc.
  - Otherwise -> EXECUTE, exec counter<=EXEC_CYCLES-1.
- EXECUTE:
  - alu_en=1 every cycle in this state.
  - Counter decrements; at 0 -> WRITEBACK.
  - EXEC_CYCLES=1 gives exactly one cycle here.
- WRITEBACK (1 cycle):
  - rf_we=dec_writeenable.
  - pc<=pc+4, wrapping modulo 2^PC_WIDTH.
  - Next state FETCH.
- EXCEPT:
  - rf_we=0, alu_en=0, inst_ready=0.
  - Holds until exc_ack=1: then exc_valid<=0, pc<=exc_pc+4, next FETCH.
  - exc_ack outside EXCEPT is ignored.
- Latency: non-faulting instruction accepted at cycle T retires (rf_we) at T+2+EXEC_CYCLES; the next inst_ready rises at T+3+EXEC_CYCLES.
- halt is sampled only in FETCH. Asserting halt during DECODE/EXECUTE still completes that instruction.
- pc is stable from FETCH acceptance through WRITEBACK.

Optional Feature:
- Macro MIPS_SEQ_PERF_EN.
- When defined, add output retired_cnt [31:0] and output exc_cnt [15:0]:
  - retired_cnt increments in each WRITEBACK cycle.
  - exc_cnt increments on DECODE->EXCEPT.
  - Both reset to 0 and wrap.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package mips_seq_pkg holds:
  - state enum (FETCH, DECODE, EXECUTE, WRITEBACK, EXCEPT), 3-bit encoding;
  - localparams OPCODE_MSB/LSB, FUNCT_MSB/LSB, PC_STEP=4.
- One natural sub-module: mips_seq_exec_timer, a down-counter with load/done for EXECUTE.
- Everything else stays flat in mips_arith_sequencer.

Test Plan:
- Reset: hold reset_n=0 2 cycles then release -> pc=0x00400000, inst_ready=1 next cycle, rf_we=0, exc_valid=0.
- add $3,$1,$2 (0x00221820), dec_writeenable=1, EXEC_CYCLES=1:
  - accepted cycle T -> opcode=0, funct=0x20 at T+1; alu_en at T+2; rf_we at T+3; pc=0x00400004 at T+4.
- Back-to-back: inst_valid held with 3 instructions -> three rf_we pulses 4 cycles apart; pc ends 0x0040000C.
- Exception:
  - opcode 0x3F with dec_except=1 -> exc_valid=1, exc_pc=0x00400000, no rf_we.
  - exc_ack pulse -> exc_valid=0, pc=0x00400004, inst_ready=1.
- EXEC_CYCLES=3 with halt raised during EXECUTE -> alu_en high exactly 3 cycles, rf_we once, then inst_ready stays 0 until halt=0.
- Reset asserted during EXECUTE -> no rf_we; state FETCH, pc=RESET_PC. With MIPS_SEQ_PERF_EN, retired_cnt=0.
